// File: rtl/ex_macc_pkg.sv
// Shared definitions for the multiply / multiply-accumulate unit:
// bus widths, operation codes, FSM states and small op-decode helpers.
package ex_macc_pkg;

    localparam int REG_W  = 32;   // RegBus
    localparam int DREG_W = 64;   // DoubleRegBus {HI,LO}
    localparam int CNT_W  = 6;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_MADD  = 3'd2,
        OP_MADDU = 3'd3,
        OP_MSUB  = 3'd4,
        OP_MSUBU = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Signed variants work on magnitudes and fix the sign afterwards.
    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    // Accumulate variants take one extra cycle to fold in HI/LO.
    function automatic logic op_is_acc(input op_e op);
        return (op == OP_MADD) || (op == OP_MADDU) ||
               (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic op_is_sub(input op_e op);
        return (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

endpackage

// File: rtl/ex_macc_mul_iter.sv
// Radix-2 shift-add iteration datapath: one multiplier bit per step,
// LSB first. The multiplicand is held stable by the caller for the
// whole operation; this block owns the accumulator, the multiplier
// shift register and the step counter.
module mul_iter
    import ex_macc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [REG_W-1:0]  i_mcand,
    input  logic [REG_W-1:0]  i_mplier,
    output logic [DREG_W-1:0] o_acc_next,
    output logic              o_last
);

    logic [DREG_W-1:0] r_acc;
    logic [REG_W-1:0]  r_mplier;
    logic [CNT_W-1:0]  r_cnt;
    logic [DREG_W-1:0] w_addend;

    // Partial product for the current bit, aligned by the step count.
    assign w_addend   = r_mplier[0] ? ({{REG_W{1'b0}}, i_mcand} << r_cnt) : '0;
    assign o_acc_next = r_acc + w_addend;
    assign o_last     = (r_cnt == CNT_W'(REG_W - 1));

    // Load clears the accumulator; each step consumes one multiplier bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_acc    <= '0;
            r_mplier <= i_mplier;
            r_cnt    <= '0;
        end else if (i_step) begin
            r_acc    <= o_acc_next;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ex_macc.sv
// Multi-cycle MULT/MULTU/MADD/MADDU/MSUB/MSUBU unit for the EX stage.
// Operands are captured once at accept; the result is presented in DONE
// and held while EX keeps start_i asserted.
module ex_macc
    import ex_macc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              annul_i,
    input  logic [2:0]        op_i,
    input  logic [REG_W-1:0]  opdata1_i,
    input  logic [REG_W-1:0]  opdata2_i,
    input  logic [DREG_W-1:0] hilo_i,
    output logic [DREG_W-1:0] result_o,
    output logic              ready_o,
    output logic              stallreq_o
);

    state_e            r_state;
    state_e            w_state_next;
    op_e               r_op;
    logic [REG_W-1:0]  r_abs1;
    logic              r_sign;
    logic [DREG_W-1:0] r_hilo;
    logic [DREG_W-1:0] r_result;

    op_e               w_op_in;
    logic              w_in_signed;
    logic [REG_W-1:0]  w_abs1;
    logic [REG_W-1:0]  w_abs2;
    logic              w_zero;
    logic              w_accept;
    logic              w_step;
    logic [DREG_W-1:0] w_acc_next;
    logic              w_last;

    assign w_op_in     = op_e'(op_i);
    assign w_in_signed = op_is_signed(w_op_in);
    assign w_abs1      = (w_in_signed && opdata1_i[REG_W-1]) ? -opdata1_i : opdata1_i;
    assign w_abs2      = (w_in_signed && opdata2_i[REG_W-1]) ? -opdata2_i : opdata2_i;
    assign w_zero      = (opdata1_i == '0) || (opdata2_i == '0);
    assign w_accept    = (r_state == ST_IDLE) && start_i && !annul_i;
    assign w_step      = (r_state == ST_MUL) && !annul_i;

    mul_iter u_mul_iter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_step     (w_step),
        .i_mcand    (r_abs1),
        .i_mplier   (w_abs2),
        .o_acc_next (w_acc_next),
        .o_last     (w_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state decode; a flush wins over everything else.
    always_comb begin
        w_state_next = r_state;
        if (annul_i) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (start_i) begin
                    if (w_zero) w_state_next = op_is_acc(w_op_in) ? ST_ACC : ST_DONE;
                    else        w_state_next = ST_MUL;
                end
                ST_MUL:  if (w_last) w_state_next = op_is_acc(r_op) ? ST_ACC : ST_DONE;
                ST_ACC:  w_state_next = ST_DONE;
                ST_DONE: if (!start_i) w_state_next = ST_IDLE;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Operand capture at accept, sign fix after the last step, HI/LO fold in ACC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= OP_MULT;
            r_abs1   <= '0;
            r_sign   <= 1'b0;
            r_hilo   <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op     <= w_op_in;
            r_abs1   <= w_abs1;
            r_sign   <= w_in_signed && (opdata1_i[REG_W-1] ^ opdata2_i[REG_W-1]);
            r_hilo   <= hilo_i;
            r_result <= '0;   // zero-skip product; its negation is also 0
        end else if (w_step && w_last) begin
            r_result <= r_sign ? -w_acc_next : w_acc_next;
        end else if ((r_state == ST_ACC) && !annul_i) begin
            r_result <= op_is_sub(r_op) ? (r_hilo - r_result) : (r_hilo + r_result);
        end
    end

    assign ready_o    = (r_state == ST_DONE);
    assign result_o   = ready_o ? r_result : '0;
    assign stallreq_o = start_i && !ready_o;

endmodule

// File: tb/tb_ex_macc.sv
// Bench for ex_macc: fixed vector table, flush/reset sequences and
// random operations compared with an arithmetic reference model.
module tb_ex_macc;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic [2:0]  op_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] hilo_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, MADD = 3'd2,
                           MADDU = 3'd3, MSUB = 3'd4, MSUBU = 3'd5;

    ex_macc dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .op_i       (op_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .hilo_i     (hilo_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] h;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: full-width product from the arithmetic meaning of the op.
    function automatic logic [63:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [63:0] h);
        logic signed [63:0] sa, sb;
        logic [63:0] prod;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        if (op == MULT || op == MADD || op == MSUB) prod = sa * sb;
        else                                        prod = {32'd0, a} * {32'd0, b};
        if (op == MADD || op == MADDU) return h + prod;
        if (op == MSUB || op == MSUBU) return h - prod;
        return prod;
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int l;
        l = (a == 0 || b == 0) ? 1 : 33;
        if (op >= MADD) l++;
        return l;
    endfunction

    // Issue one op, scramble inputs after accept, measure latency, check
    // result, hold behaviour in DONE and return to IDLE after start drops.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] h,
                          input logic [63:0] exp, input int exp_lat);
        int lat;
        logic [63:0] res;
        @(negedge clk);
        start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b; hilo_i = h;
        @(posedge clk); #1;
        lat = 1;
        opdata1_i = $urandom; opdata2_i = $urandom; hilo_i = {$urandom, $urandom};
        if (!ready_o) begin
            chk({tag, " busy_stall"}, 64'(stallreq_o), 64'd1);
            chk({tag, " busy_result"}, result_o, 64'd0);
        end
        while (!ready_o && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " result"}, result_o, exp);
        chk({tag, " done_stall"}, 64'(stallreq_o), 64'd0);
        res = result_o;
        @(negedge clk);
        op_i = 3'($urandom_range(0, 5)); opdata1_i = $urandom; opdata2_i = $urandom;
        @(posedge clk); #1;
        chk({tag, " hold_ready"}, 64'(ready_o), 64'd1);
        chk({tag, " hold_result"}, result_o, res);
        $display("%s op=%0d a=%h b=%h h=%h -> result=%h lat=%0d", tag, op, a, b, h, res, lat);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
        chk({tag, " idle_ready"}, 64'(ready_o), 64'd0);
        chk({tag, " idle_result"}, result_o, 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'd0;
        if (r == 1) return 32'h8000_0000;
        if (r == 2) return 32'hFFFF_FFFF;
        return $urandom;
    endfunction

    initial begin
        int highs;
        logic [31:0] ra, rb;
        logic [63:0] rh;
        logic [2:0]  rop;

        vecs[0] = '{MULT,  32'd7,          32'hFFFF_FFFD, 64'd0,    64'hFFFF_FFFF_FFFF_FFEB, 33};
        vecs[1] = '{MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 64'd0,    64'hFFFF_FFFE_0000_0001, 33};
        vecs[2] = '{MADD,  32'd2,          32'd3,         64'h10,   64'h16,                  34};
        vecs[3] = '{MSUBU, 32'd1,          32'd1,         64'd0,    64'hFFFF_FFFF_FFFF_FFFF, 34};
        vecs[4] = '{MADD,  32'd0,          32'd7,         64'h55,   64'h55,                  2};
        vecs[5] = '{MULT,  32'd0,          32'd5,         64'd0,    64'd0,                   1};
        vecs[6] = '{MULT,  32'h8000_0000,  32'hFFFF_FFFF, 64'd0,    64'h0000_0000_8000_0000, 33};
        vecs[7] = '{MSUB,  32'hFFFF_FFFE,  32'd3,         64'd0,    64'd6,                   34};
        vecs[8] = '{MULTU, 32'h8000_0000,  32'd2,         64'd0,    64'h0000_0001_0000_0000, 33};
        vecs[9] = '{MADDU, 32'hFFFF_FFFF,  32'd2,         64'd1,    64'h0000_0001_FFFF_FFFF, 34};

        rst = 1'b1; start_i = 1'b1; annul_i = 1'b0; op_i = MULT;
        opdata1_i = 32'd9; opdata2_i = 32'd9; hilo_i = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_result", result_o, 64'd0);
        chk("reset_stall", 64'(stallreq_o), 64'd1);
        @(negedge clk);
        rst = 1'b0; start_i = 1'b0;

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].h,
                   vecs[i].exp, vecs[i].lat);

        // Flush in the middle of a multiply.
        @(negedge clk);
        start_i = 1'b1; op_i = MULT; opdata1_i = 32'd123; opdata2_i = 32'd456;
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1;
        annul_i = 1'b1; start_i = 1'b0;
        @(posedge clk); #1;
        annul_i = 1'b0;
        chk("annul_ready", 64'(ready_o), 64'd0);
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready_o) highs++;
        end
        chk("annul_no_ready", 64'(highs), 64'd0);
        $display("annul sequence: ready pulses after flush=%0d", highs);
        run_op("annul_next", MULT, 32'd4, 32'd4, 64'd0, 64'h10, 33);

        // Reset in the middle of a multiply.
        @(negedge clk);
        start_i = 1'b1; op_i = MADDU; opdata1_i = 32'h1234_5678; opdata2_i = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ready", 64'(ready_o), 64'd0);
        chk("midrst_result", result_o, 64'd0);
        chk("midrst_stall", 64'(stallreq_o), 64'd1);
        rst = 1'b0; start_i = 1'b0;
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready_o) highs++;
        end
        chk("midrst_no_ready", 64'(highs), 64'd0);
        $display("reset sequence: ready pulses after reset=%0d", highs);
        run_op("post_rst", MADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd5, 64'd6, 34);

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 5));
            ra  = pick_operand();
            rb  = pick_operand();
            rh  = {$urandom, $urandom};
            run_op($sformatf("rnd%0d", i), rop, ra, rb, rh,
                   model_result(rop, ra, rb, rh), model_lat(rop, ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
